// File: rtl/tama_report_scheduler.sv
// Report frame scheduler: arbitrates alert / host / periodic reports onto a valid/ready byte stream.
// Build option REPORT_CHECKSUM_EN appends an XOR checksum byte (7-byte frame instead of 6).
module tama_report_scheduler #(
    parameter int unsigned REPORT_PERIOD = 4,
    parameter logic [4:0]  ALERT_LEVEL   = 5'd4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       second,
    input  logic [4:0] hunger,
    input  logic [4:0] happiness,
    input  logic [4:0] hygiene,
    input  logic [4:0] energy,
    input  logic       is_sleeping,
    input  logic       cmd_valid,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic       alert,
    output logic [7:0] frame_count
);

`ifdef REPORT_CHECKSUM_EN
    localparam int unsigned N_BYTES = 7;
`else
    localparam int unsigned N_BYTES = 6;
`endif
    localparam logic [2:0] LAST_IDX     = 3'(N_BYTES - 1);
    localparam logic [7:0] PERIOD_LAST  = 8'(REPORT_PERIOD - 1);
    localparam logic [7:0] HDR_ALERT    = 8'hAE;
    localparam logic [7:0] HDR_HOST     = 8'hA0;
    localparam logic [7:0] HDR_PERIODIC = 8'hA5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2
    } state_t;

    state_t state_reg, state_next;

    // Index 3 is hunger so that low flag bit3 and the stat byte order line up.
    logic [3:0][4:0] stat_in;
    logic [3:0][4:0] snap_reg;
    logic [3:0]      low_next, low_reg, snap_low_reg;
    logic            snap_sleep_reg;
    logic            alert_pend_reg, host_pend_reg, per_pend_reg;
    logic            alert_set, per_set;
    logic            clr_alert, clr_host, clr_per;
    logic            snap_en, frame_done;
    logic [7:0]      period_cnt_reg;
    logic [7:0]      header_reg, header_next;
    logic [7:0]      frame_count_reg;
    logic [2:0]      idx_reg, idx_next;
    logic [7:0]      frame_byte;

    assign stat_in = {hunger, happiness, hygiene, energy};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_low
            assign low_next[gi] = (stat_in[gi] < ALERT_LEVEL);
        end
    endgenerate

    assign alert_set = |(low_next & ~low_reg);
    assign per_set   = second && (period_cnt_reg == PERIOD_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // New events win over a same-cycle clear so no request is ever dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_reg         <= '0;
            header_reg      <= '0;
            low_reg         <= '0;
            alert_pend_reg  <= 1'b0;
            host_pend_reg   <= 1'b0;
            per_pend_reg    <= 1'b0;
            period_cnt_reg  <= '0;
            frame_count_reg <= '0;
            snap_reg        <= '0;
            snap_low_reg    <= '0;
            snap_sleep_reg  <= 1'b0;
        end else begin
            idx_reg        <= idx_next;
            header_reg     <= header_next;
            low_reg        <= low_next;
            alert_pend_reg <= alert_set | (alert_pend_reg & ~clr_alert);
            host_pend_reg  <= cmd_valid | (host_pend_reg & ~clr_host);
            per_pend_reg   <= per_set | (per_pend_reg & ~clr_per);
            if (second) begin
                period_cnt_reg <= (period_cnt_reg == PERIOD_LAST) ? 8'd0 : period_cnt_reg + 8'd1;
            end
            if (frame_done) begin
                frame_count_reg <= frame_count_reg + 8'd1;
            end
            if (snap_en) begin
                snap_reg       <= stat_in;
                snap_low_reg   <= low_reg;
                snap_sleep_reg <= is_sleeping;
            end
        end
    end

    always_comb begin
        state_next  = state_reg;
        idx_next    = idx_reg;
        header_next = header_reg;
        clr_alert   = 1'b0;
        clr_host    = 1'b0;
        clr_per     = 1'b0;
        snap_en     = 1'b0;
        frame_done  = 1'b0;
        tx_valid    = 1'b0;
        tx_data     = 8'h00;
        case (state_reg)
            IDLE: begin
                if (alert_pend_reg || host_pend_reg || per_pend_reg) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                state_next = SEND;
                idx_next   = '0;
                snap_en    = 1'b1;
                if (alert_pend_reg) begin
                    clr_alert   = 1'b1;
                    header_next = HDR_ALERT;
                end else if (host_pend_reg) begin
                    clr_host    = 1'b1;
                    header_next = HDR_HOST;
                end else begin
                    clr_per     = 1'b1;
                    header_next = HDR_PERIODIC;
                end
            end
            SEND: begin
                tx_valid = 1'b1;
                tx_data  = frame_byte;
                if (tx_ready) begin
                    if (idx_reg == LAST_IDX) begin
                        idx_next   = '0;
                        state_next = IDLE;
                        frame_done = 1'b1;
                    end else begin
                        idx_next = idx_reg + 3'd1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef REPORT_CHECKSUM_EN
    logic [7:0] checksum;
    assign checksum = header_reg ^ {3'b000, snap_reg[3]} ^ {3'b000, snap_reg[2]}
                    ^ {3'b000, snap_reg[1]} ^ {3'b000, snap_reg[0]}
                    ^ {3'b000, snap_sleep_reg, snap_low_reg};
`endif

    always_comb begin
        frame_byte = 8'h00;
        case (idx_reg)
            3'd0: frame_byte = header_reg;
            3'd1: frame_byte = {3'b000, snap_reg[3]};
            3'd2: frame_byte = {3'b000, snap_reg[2]};
            3'd3: frame_byte = {3'b000, snap_reg[1]};
            3'd4: frame_byte = {3'b000, snap_reg[0]};
            3'd5: frame_byte = {3'b000, snap_sleep_reg, snap_low_reg};
`ifdef REPORT_CHECKSUM_EN
            3'd6: frame_byte = checksum;
`endif
            default: frame_byte = 8'h00;
        endcase
    end

    assign busy        = (state_reg != IDLE);
    assign alert       = |low_reg;
    assign frame_count = frame_count_reg;

endmodule

// File: tb/tb_tama_report_scheduler.sv
// Directed bench for tama_report_scheduler: scoreboard of expected frame bytes popped on each transfer.
// A second instance with REPORT_PERIOD=3 checks the period counter.
module tb_tama_report_scheduler;

`ifdef REPORT_CHECKSUM_EN
    localparam int N_BYTES = 7;
`else
    localparam int N_BYTES = 6;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       second;
    logic [4:0] hunger, happiness, hygiene, energy;
    logic       is_sleeping;
    logic       cmd_valid;
    logic       tx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       busy;
    logic       alert;
    logic [7:0] frame_count;

    logic       tx_ready2;
    logic [7:0] tx_data2;
    logic       tx_valid2;
    logic       busy2;
    logic       alert2;
    logic [7:0] frame_count2;

    int n_cmp = 0;
    int n_err = 0;
    int n_xfer = 0;
    int exp_fc = 0;
    logic [7:0] sb[$];

    always #5 clk = ~clk;

    tama_report_scheduler #(.REPORT_PERIOD(1), .ALERT_LEVEL(5'd4)) dut (
        .clk(clk), .rst_n(rst_n), .second(second),
        .hunger(hunger), .happiness(happiness), .hygiene(hygiene), .energy(energy),
        .is_sleeping(is_sleeping), .cmd_valid(cmd_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .alert(alert), .frame_count(frame_count)
    );

    tama_report_scheduler #(.REPORT_PERIOD(3), .ALERT_LEVEL(5'd4)) dut_p3 (
        .clk(clk), .rst_n(rst_n), .second(second),
        .hunger(hunger), .happiness(happiness), .hygiene(hygiene), .energy(energy),
        .is_sleeping(is_sleeping), .cmd_valid(cmd_valid),
        .tx_data(tx_data2), .tx_valid(tx_valid2), .tx_ready(tx_ready2),
        .busy(busy2), .alert(alert2), .frame_count(frame_count2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_frame(input logic [7:0] hdr, input logic [4:0] h, input logic [4:0] ha,
                              input logic [4:0] hy, input logic [4:0] en,
                              input logic sl, input logic [3:0] lw);
        logic [7:0] b [7];
        b[0] = hdr;
        b[1] = {3'b000, h};
        b[2] = {3'b000, ha};
        b[3] = {3'b000, hy};
        b[4] = {3'b000, en};
        b[5] = {3'b000, sl, lw};
        b[6] = b[0] ^ b[1] ^ b[2] ^ b[3] ^ b[4] ^ b[5];
        for (int i = 0; i < N_BYTES; i++) sb.push_back(b[i]);
    endtask

    // Both pulse tasks return 1ns after the edge that samples the event.
    task automatic pulse_second();
        @(posedge clk); #1 second = 1'b1;
        @(posedge clk); #1 second = 1'b0;
    endtask

    task automatic pulse_cmd();
        @(posedge clk); #1 cmd_valid = 1'b1;
        @(posedge clk); #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_frames(input string tag, input int target);
        int cyc = 0;
        while (frame_count !== 8'(target) && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_frame_count"}, 32'(frame_count), 32'(target));
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
    endtask

    // Scoreboard monitor: a byte is consumed on the edge following a negedge with valid & ready.
    logic       prev_stall = 1'b0;
    logic [7:0] held = 8'h00;
    always @(negedge clk) begin
        logic [7:0] exp_b;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid_held", 32'(tx_valid), 32'd1);
                check("stall_data_held", 32'(tx_data), 32'(held));
            end
            if (tx_valid && tx_ready) begin
                if (sb.size() == 0) begin
                    check("spurious_tx_valid", 32'(tx_valid), 32'd0);
                end else begin
                    exp_b = sb.pop_front();
                    $display("xfer %0d: data=%02h expected=%02h", n_xfer, tx_data, exp_b);
                    n_xfer++;
                    check("frame_byte", 32'(tx_data), 32'(exp_b));
                end
            end
            prev_stall = tx_valid && !tx_ready;
            held       = tx_data;
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "timeout");
    end

    initial begin
        int bad;
        rst_n = 1'b0; second = 1'b0; cmd_valid = 1'b0; tx_ready = 1'b1; tx_ready2 = 1'b1;
        hunger = 5'd10; happiness = 5'd20; hygiene = 5'd30; energy = 5'd31; is_sleeping = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'h00);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_alert", 32'(alert), 32'd0);
        check("rst_frame_count", 32'(frame_count), 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("idle_after_release", 32'(busy), 32'd0);

        // Periodic frame with latency check.
        push_frame(8'hA5, 5'd10, 5'd20, 5'd30, 5'd31, 1'b0, 4'b0000);
        pulse_second();
        @(negedge clk);
        check("lat_k_valid", 32'(tx_valid), 32'd0);
        check("lat_k_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("lat_k1_valid", 32'(tx_valid), 32'd0);
        check("lat_k1_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("lat_k2_valid", 32'(tx_valid), 32'd1);
        check("lat_k2_header", 32'(tx_data), 32'hA5);
        exp_fc++;
        wait_frames("periodic", exp_fc);
        check("p3_no_frame_tick1", 32'(frame_count2), 32'd0);

        // Backpressure on byte2.
        push_frame(8'hA5, 5'd10, 5'd20, 5'd30, 5'd31, 1'b0, 4'b0000);
        pulse_second();
        repeat (4) @(posedge clk);
        #1 tx_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("bp_data", 32'(tx_data), 32'h14);
            check("bp_valid", 32'(tx_valid), 32'd1);
            @(posedge clk);
        end
        #1 tx_ready = 1'b1;
        exp_fc++;
        wait_frames("backpressure", exp_fc);
        check("p3_no_frame_tick2", 32'(frame_count2), 32'd0);
        check("p3_idle_tick2", 32'(busy2), 32'd0);

        // Third tick: period-3 instance emits its first frame.
        push_frame(8'hA5, 5'd10, 5'd20, 5'd30, 5'd31, 1'b0, 4'b0000);
        pulse_second();
        exp_fc++;
        wait_frames("tick3", exp_fc);
        repeat (2) @(negedge clk);
        check("p3_frame_tick3", 32'(frame_count2), 32'd1);

        // Simultaneous alert, host and periodic events.
        push_frame(8'hAE, 5'd2, 5'd20, 5'd30, 5'd31, 1'b0, 4'b1000);
        push_frame(8'hA0, 5'd2, 5'd20, 5'd30, 5'd31, 1'b0, 4'b1000);
        push_frame(8'hA5, 5'd2, 5'd20, 5'd30, 5'd31, 1'b0, 4'b1000);
        @(posedge clk);
        #1 hunger = 5'd2; cmd_valid = 1'b1; second = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0; second = 1'b0;
        exp_fc += 3;
        bad = 0;
        for (int cyc = 0; cyc < 300 && frame_count !== 8'(exp_fc); cyc++) begin
            @(negedge clk);
            if (alert !== 1'b1) bad++;
        end
        check("simul_frame_count", 32'(frame_count), 32'(exp_fc));
        check("simul_alert_low_cycles", 32'(bad), 32'd0);
        check("simul_alert_end", 32'(alert), 32'd1);
        hunger = 5'd10;
        repeat (3) @(negedge clk);
        check("alert_cleared", 32'(alert), 32'd0);
        check("no_frame_on_fall", 32'(busy), 32'd0);

        // Snapshot: energy changes while byte1 is on the wire.
        push_frame(8'hA5, 5'd10, 5'd20, 5'd30, 5'd31, 1'b0, 4'b0000);
        pulse_second();
        repeat (3) @(posedge clk);
        #1 energy = 5'd5;
        exp_fc++;
        wait_frames("snap_first", exp_fc);
        push_frame(8'hA5, 5'd10, 5'd20, 5'd30, 5'd5, 1'b0, 4'b0000);
        pulse_second();
        exp_fc++;
        wait_frames("snap_second", exp_fc);

        // Reset while byte3 is presented.
        push_frame(8'hA0, 5'd10, 5'd20, 5'd30, 5'd5, 1'b0, 4'b0000);
        pulse_cmd();
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_tx_valid", 32'(tx_valid), 32'd0);
        check("midrst_frame_count", 32'(frame_count), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_bytes_left", 32'(sb.size()), 32'(N_BYTES - 3));
        sb.delete();
        exp_fc = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        bad = 0;
        repeat (8) begin
            @(negedge clk);
            if (busy !== 1'b0 || tx_valid !== 1'b0) bad++;
        end
        check("post_rst_quiet_cycles", 32'(bad), 32'd0);

        // Alert threshold boundary: 4 is not low, 3 is.
        is_sleeping = 1'b1;
        hygiene = 5'd4;
        repeat (6) @(negedge clk);
        check("boundary_4_alert", 32'(alert), 32'd0);
        check("boundary_4_busy", 32'(busy), 32'd0);
        push_frame(8'hAE, 5'd10, 5'd20, 5'd3, 5'd5, 1'b1, 4'b0010);
        hygiene = 5'd3;
        exp_fc++;
        wait_frames("boundary_3", exp_fc);
        check("boundary_3_alert", 32'(alert), 32'd1);

        push_frame(8'hA0, 5'd10, 5'd20, 5'd3, 5'd5, 1'b1, 4'b0010);
        pulse_cmd();
        exp_fc++;
        wait_frames("host_sleep", exp_fc);
        repeat (4) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/tama_report_scheduler.md
# tama_report_scheduler

Frame scheduler that shares the tamagotchi's single UART transmit path between three report sources: periodic status, low-stat alerts and host requests. It snapshots the four 5-bit stats and the sleep flag, builds a fixed byte frame, and streams it over a valid/ready byte handshake to the UART transmitter. It sits between the stats block, the UART RX command decoder and the UART TX byte engine.

## Interface
- REPORT_PERIOD, 4: number of `second` ticks between periodic frames; legal range 1..255.
- ALERT_LEVEL, 5'd4: a stat strictly below this value is "low".
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- second  in  1  one-cycle tick, once per second.
- hunger, happiness, hygiene, energy  in  5 each  current stats.
- is_sleeping  in  1  pet asleep.
- cmd_valid  in  1  one-cycle host report request.
- tx_data  out  8  frame byte.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  transmitter accepts the byte this cycle.
- busy  out  1  high whenever state is not IDLE.
- alert  out  1  registered OR of the four low flags.
- frame_count  out  8  completed frames, wraps 255->0.

## Operation
- Low flags: low[3:0] = {hunger, happiness, hygiene, energy} < ALERT_LEVEL. Registered every cycle.
- Pending flags:
  - alert_pend is set when any low bit goes 0->1 versus the previous cycle.
  - host_pend is set by cmd_valid.
  - per_pend is set when `second` arrives with the period counter at REPORT_PERIOD-1.
- Period counter: counts `second` ticks 0..REPORT_PERIOD-1 and wraps. It runs continuously, including during frames.
- Repeated events of one type before that type is served collapse into a single pending request.
- States:
  - IDLE -> LOAD when any pending flag is set.
  - LOAD (1 cycle): selects a type with priority alert > host > periodic, clears only that pending flag, latches the header.
  - LOAD -> SEND: the stats, is_sleeping and low flags are snapshotted on this edge.
  - SEND: steps byte index 0..N-1; after the last accepted byte, go to IDLE and increment frame_count.
- Frame bytes:
  - 0: header, 0xAE alert / 0xA0 host / 0xA5 periodic.
  - 1-4: {3'b0, stat}, in the order hunger, happiness, hygiene, energy.
  - 5: flags {3'b0, is_sleeping, low[3:0]}, with bit3 = hunger.
  - 6: checksum (see Configuration).
- Events arriving during a frame only set pending flags. They are served in priority order after the frame returns to IDLE.
- Input stats changing mid-frame do not affect the frame in progress (snapshot only).

## Timing
- Handshake:
  - tx_valid is high in SEND only.
  - tx_data stays stable while tx_valid=1 and tx_ready=0.
  - A byte transfers on a rising edge with tx_valid=1 and tx_ready=1.
  - The next byte is presented the following cycle with no bubble.
- Latency: an event sampled at edge k sets pending at k; LOAD at k+1; SEND with tx_valid=1 and byte0 at k+2.
- Back-to-back frames: IDLE is held for exactly 1 cycle between frames (last byte edge -> IDLE -> LOAD -> SEND).
- Throughput with tx_ready held 1: N transfers in N consecutive cycles.
- Reset values: tx_valid=0, tx_data=0x00, busy=0, alert=0, frame_count=0, all pending flags, the period counter and the low-flag history cleared, state IDLE.
- Reset asserted mid-frame aborts the frame immediately; nothing resumes after release.
- First cycle after reset: the low-flag history is 0. Stats already low at reset release therefore raise alert_pend on the first clock.

## Configuration
- REPORT_CHECKSUM_EN defined: N=7; byte 6 = XOR of bytes 0..5.
- Not defined: N=6; the frame ends after the flags byte. All other behaviour is identical.

## Test plan
- Periodic frame:
  - Setup: REPORT_PERIOD=1, checksum on, tx_ready=1, stats 10/20/30/31, awake.
  - Stimulus: one `second` pulse.
  - Required: A5 0A 14 1E 1F 00 BA on consecutive cycles, tx_valid rising 2 cycles after the tick edge, then frame_count=1 and busy=0.
- Backpressure: tx_ready=0 for 5 cycles while byte2 is presented -> tx_data stays 0x14 with tx_valid high throughout; the full frame is delivered with no loss or duplication.
- Simultaneous events:
  - Stimulus: hunger 10->2, cmd_valid and `second` (REPORT_PERIOD=1) in the same cycle.
  - Required: three frames in order, headers AE, A0, A5, each with flags 0x08; alert=1 throughout.
- Snapshot: change energy 31->5 while byte1 is being sent -> the current frame's byte4 is 0x1F; the next frame carries 0x05.
- Reset mid-frame: drop rst_n during byte3 -> tx_valid=0 and frame_count=0 immediately; after release, idle with no output until a new event arrives.
- Checksum off: build without REPORT_CHECKSUM_EN, repeat the periodic-frame test -> 6 bytes A5 0A 14 1E 1F 00, then IDLE.
